mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between NREQ requesters of the risc_v core
//  (port 0 = instruction fetch, port 1 = load/store). Rotating-priority grant, one transaction
//  in flight, fixed read latency. Sits between the core's fetch/LSU and the unified memory.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter_rr_arbiter.sv | 33 +++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types, widths and index helpers for the memory port arbiter
// Purpose: FSM state encoding, default data/address width and small index helpers
//          used by the arbiter top and its round-robin grant logic.
// Ports:   none (package).
package mem_port_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wrap a non-negative index into 0..n-1.
  function automatic int wrap_idx(input int i, input int n);
    return i % n;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side bundle of the memory port arbiter
// Purpose: groups the per-requester request/response signals and the single-port memory
//          signals.
// Modports: master - the arbiter (drives ReqReady, RspValid/RspRData, Mem*; samples
//                    Req*, MemRData)
//           slave  - requesters plus memory (the opposite directions)
interface mem_port_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  localparam int BW = DW / 8;

  logic [NREQ-1:0]    ReqValid;
  logic [NREQ-1:0]    ReqReady;
  logic [NREQ-1:0]    ReqWrite;
  logic [NREQ*AW-1:0] ReqAddr;
  logic [NREQ*DW-1:0] ReqWData;
  logic [NREQ*BW-1:0] ReqBE;
  logic [NREQ-1:0]    RspValid;
  logic [DW-1:0]      RspRData;
  logic               MemEn;
  logic               MemWe;
  logic [AW-1:0]      MemAddr;
  logic [DW-1:0]      MemWData;
  logic [BW-1:0]      MemBE;
  logic [DW-1:0]      MemRData;

  modport master (
    input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqBE, MemRData,
    output ReqReady, RspValid, RspRData, MemEn, MemWe, MemAddr, MemWData, MemBE
  );

  modport slave (
    output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqBE, MemRData,
    input  ReqReady, RspValid, RspRData, MemEn, MemWe, MemAddr, MemWData, MemBE
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rtl/mem_port_arbiter_rr_arbiter.sv - combinational rotating-priority grant
// Purpose: picks the first requesting bit at or above ptr_i, wrapping around.
// Ports:   req_i     - request vector
//          ptr_i     - index holding highest priority
//          gnt_o     - one-hot grant (zero when no request)
//          gnt_idx_o - index of the granted bit (0 when no request)
module rr_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  // Scan offsets from farthest to nearest so the last hit (nearest to ptr) wins,
  // which avoids a separate found flag.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap_idx(int'(ptr_i) + k, N)]) begin
        gnt_o                             = '0;
        gnt_o[wrap_idx(int'(ptr_i) + k, N)] = 1'b1;
        gnt_idx_o                         = IW'(wrap_idx(int'(ptr_i) + k, N));
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - rotating-priority sharing of one single-port synchronous memory
// Purpose: grants one requester at a time, runs a single memory access, waits the fixed
//          read latency and returns a one-cycle response to the owner.
// Ports:   CLK   - clock, all state on rising edge
//          Reset - asynchronous active-low reset
//          bus   - request/response and memory signals (mem_port_arbiter_if.master)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int AW     = XLEN,
  parameter int DW     = XLEN,
  parameter int RD_LAT = 1
) (
  input  logic                      CLK,
  input  logic                      Reset,
  mem_port_arbiter_if.master        bus
);

  localparam int BW = DW / 8;
  localparam int IW = idx_width(NREQ);
  localparam int CW = idx_width(RD_LAT);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [BW-1:0] mem_be_q, mem_be_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req_i     (bus.ReqValid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata_q     <= rdata_d;
    end
  end

  // The Mem* registers double as the request latch: they are loaded at grant so the
  // strobe appears in ACCESS, and address/data/BE simply hold afterwards.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    rdata_d      = rdata_q;
    bus.ReqReady = '0;
    bus.RspValid = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (|bus.ReqValid) begin
          bus.ReqReady = gnt;
          owner_d      = gnt_idx;
          wr_d         = bus.ReqWrite[gnt_idx];
          mem_en_d     = 1'b1;
          mem_we_d     = bus.ReqWrite[gnt_idx];
          mem_addr_d   = bus.ReqAddr[int'(gnt_idx) * AW +: AW];
          mem_wdata_d  = bus.ReqWData[int'(gnt_idx) * DW +: DW];
          mem_be_d     = bus.ReqBE[int'(gnt_idx) * BW +: BW];
          ptr_d        = IW'(wrap_idx(int'(gnt_idx) + 1, NREQ));
          state_d      = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (wr_q) begin
          state_d = ARB_RESP;
        end else begin
          cnt_d   = CW'(RD_LAT - 1);
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = bus.MemRData;
          state_d = ARB_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ARB_RESP: begin
        bus.RspValid[owner_q] = 1'b1;
        state_d               = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.MemEn    = mem_en_q;
  assign bus.MemWe    = mem_we_q;
  assign bus.MemAddr  = mem_addr_q;
  assign bus.MemWData = mem_wdata_q;
  assign bus.MemBE    = mem_be_q;
  assign bus.RspRData = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (RD_LAT 1 and 3)
module tb_mem_port_arbiter;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] data;
  } exp_t;

  logic CLK   = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.NREQ(2), .AW(32), .DW(32)) if1 ();
  mem_port_arbiter_if #(.NREQ(2), .AW(32), .DW(32)) if3 ();

  mem_port_arbiter #(.NREQ(2), .AW(32), .DW(32), .RD_LAT(1)) u_dut1 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (if1.master)
  );

  mem_port_arbiter #(.NREQ(2), .AW(32), .DW(32), .RD_LAT(3)) u_dut3 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (if3.master)
  );

  int total = 0;
  int bad   = 0;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] ref1 [64];
  logic [31:0] rd1;
  logic [31:0] p3 [3];

  assign if1.MemRData = rd1;
  assign if3.MemRData = p3[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory behind DUT1: one-cycle read latency, byte-enabled writes.
  always @(posedge CLK) begin
    if (!Reset) begin
      for (int i = 0; i < 64; i++) mem1[i] <= (i == 4) ? 32'hDEAD_BEEF : 32'h0;
      rd1 <= 32'h0;
    end else if (if1.MemEn) begin
      if (if1.MemWe) begin
        for (int b = 0; b < 4; b++)
          if (if1.MemBE[b]) mem1[if1.MemAddr[7:2]][8*b +: 8] <= if1.MemWData[8*b +: 8];
      end else begin
        rd1 <= mem1[if1.MemAddr[7:2]];
      end
    end
  end

  // Memory behind DUT3: read data presented only in the third cycle after MemEn.
  always @(posedge CLK) begin
    if (!Reset) begin
      for (int i = 0; i < 64; i++) mem3[i] <= (i == 4) ? 32'hCAFE_F00D : 32'h0;
      for (int s = 0; s < 3; s++) p3[s] <= 32'h0;
    end else begin
      p3[0] <= (if3.MemEn && !if3.MemWe) ? mem3[if3.MemAddr[7:2]] : 32'h0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end

  // Response scoreboards.
  always @(negedge CLK) begin
    if (Reset && if1.RspValid != 2'b00) begin
      if (q1.size() == 0) begin
        check("rsp1_unexpected", 64'(if1.RspValid), 64'd0);
      end else begin
        e1 = q1.pop_front();
        check("rsp1_port", 64'(if1.RspValid), 64'(2'b01 << e1.port));
        if (!e1.wr) check("rsp1_data", 64'(if1.RspRData), 64'(e1.data));
      end
    end
  end

  always @(negedge CLK) begin
    if (Reset && if3.RspValid != 2'b00) begin
      if (q3.size() == 0) begin
        check("rsp3_unexpected", 64'(if3.RspValid), 64'd0);
      end else begin
        e3 = q3.pop_front();
        check("rsp3_port", 64'(if3.RspValid), 64'(2'b01 << e3.port));
        if (!e3.wr) check("rsp3_data", 64'(if3.RspRData), 64'(e3.data));
      end
    end
  end

  task automatic push1(input int p, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    e.port = p;
    e.wr   = wr;
    e.data = ref1[a[7:2]];
    q1.push_back(e);
    if (wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref1[a[7:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  // Called at a negedge; returns at the negedge where the response is seen.
  task automatic do_req1(input int p, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input int exp_lat);
    int k;
    int lat;
    push1(p, wr, a, wd, be);
    if1.ReqWrite[p]          = wr;
    if1.ReqAddr[p*32 +: 32]  = a;
    if1.ReqWData[p*32 +: 32] = wd;
    if1.ReqBE[p*4 +: 4]      = be;
    if1.ReqValid[p]          = 1'b1;
    k = 0;
    #1;
    while (!if1.ReqReady[p] && k < 20) begin @(negedge CLK); #1; k++; end
    check("req_grant", 64'(if1.ReqReady), 64'(2'b01 << p));
    @(negedge CLK);
    if1.ReqValid[p] = 1'b0;
    check("req_memen", 64'(if1.MemEn), 64'd1);
    check("req_memwe", 64'(if1.MemWe), 64'(wr));
    check("req_memaddr", 64'(if1.MemAddr), 64'(a));
    if (wr) begin
      check("req_memwdata", 64'(if1.MemWData), 64'(wd));
      check("req_membe", 64'(if1.MemBE), 64'(be));
    end
    lat = 1;
    while (if1.RspValid == 2'b00 && lat < 20) begin @(negedge CLK); lat++; end
    check("req_latency", 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int   k, lat, cyc, last, seen;
    exp_t e;

    if1.ReqValid = '0; if1.ReqWrite = '0; if1.ReqAddr = '0; if1.ReqWData = '0; if1.ReqBE = '0;
    if3.ReqValid = '0; if3.ReqWrite = '0; if3.ReqAddr = '0; if3.ReqWData = '0; if3.ReqBE = '0;
    for (int i = 0; i < 64; i++) ref1[i] = (i == 4) ? 32'hDEAD_BEEF : 32'h0;

    // Reset state.
    repeat (2) @(negedge CLK);
    check("rst_memen", 64'(if1.MemEn), 64'd0);
    check("rst_memwe", 64'(if1.MemWe), 64'd0);
    check("rst_memaddr", 64'(if1.MemAddr), 64'd0);
    check("rst_rspvalid", 64'(if1.RspValid), 64'd0);
    check("rst_rsprdata", 64'(if1.RspRData), 64'd0);
    check("rst_reqready", 64'(if1.ReqReady), 64'd0);
    Reset = 1'b1;
    @(negedge CLK);

    // Reset during WAIT of a read on the RD_LAT=3 instance.
    if3.ReqAddr[31:0] = 32'h0000_0010;
    if3.ReqValid[0]   = 1'b1;
    k = 0;
    #1;
    while (!if3.ReqReady[0] && k < 20) begin @(negedge CLK); #1; k++; end
    check("t1_grant", 64'(if3.ReqReady), 64'd1);
    @(negedge CLK);
    if3.ReqValid = 2'b00;
    check("t1_memen", 64'(if3.MemEn), 64'd1);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("t1_memen0", 64'(if3.MemEn), 64'd0);
    check("t1_memwe0", 64'(if3.MemWe), 64'd0);
    check("t1_memaddr0", 64'(if3.MemAddr), 64'd0);
    check("t1_memwdata0", 64'(if3.MemWData), 64'd0);
    check("t1_membe0", 64'(if3.MemBE), 64'd0);
    check("t1_rspvalid0", 64'(if3.RspValid), 64'd0);
    check("t1_rsprdata0", 64'(if3.RspRData), 64'd0);
    check("t1_reqready0", 64'(if3.ReqReady), 64'd0);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (if3.RspValid != 2'b00) seen++;
    end
    check("t1_no_rsp", 64'(seen), 64'd0);

    // RD_LAT=3 read: response 5 cycles after grant, ReqReady low meanwhile.
    e.port = 0; e.wr = 1'b0; e.data = 32'hCAFE_F00D;
    q3.push_back(e);
    if3.ReqValid[0] = 1'b1;
    k = 0;
    #1;
    while (!if3.ReqReady[0] && k < 20) begin @(negedge CLK); #1; k++; end
    check("t6_grant", 64'(if3.ReqReady), 64'd1);
    @(negedge CLK);
    if3.ReqValid = 2'b11;
    lat = 1;
    while (if3.RspValid == 2'b00 && lat < 20) begin
      #1;
      check("t6_noready", 64'(if3.ReqReady), 64'd0);
      @(negedge CLK);
      lat++;
    end
    if3.ReqValid = 2'b00;
    check("t6_latency", 64'(lat), 64'd5);
    check("t6_rspvalid", 64'(if3.RspValid), 64'd1);
    @(negedge CLK);

    // Read by requester 0 (pointer 0 -> 1).
    do_req1(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 3);
    @(negedge CLK);

    // Partial write by requester 1 (pointer 1 -> 0); read data register untouched.
    do_req1(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 2);
    check("t3_rdata_hold", 64'(if1.RspRData), 64'hDEAD_BEEF);
    @(negedge CLK);

    // Both requesters held: alternating grants starting at requester 0.
    if1.ReqWrite = 2'b00;
    if1.ReqAddr  = {32'h0000_0020, 32'h0000_0010};
    for (int g = 0; g < 6; g++) push1(g % 2, 1'b0, (g % 2 == 0) ? 32'h10 : 32'h20, 32'h0, 4'h0);
    if1.ReqValid = 2'b11;
    for (int g = 0; g < 6; g++) begin
      k = 0;
      #1;
      while (if1.ReqReady == 2'b00 && k < 20) begin @(negedge CLK); #1; k++; end
      check("t4_grant", 64'(if1.ReqReady), (g % 2 == 0) ? 64'd1 : 64'd2);
      @(negedge CLK);
    end
    if1.ReqValid = 2'b00;
    k = 0;
    while (q1.size() != 0 && k < 50) begin @(negedge CLK); k++; end
    check("t4_drain", 64'(q1.size()), 64'd0);
    @(negedge CLK);

    // Requester 1 alone, held: a grant every 3 cycles.
    if1.ReqWrite[1]     = 1'b1;
    if1.ReqBE[7:4]      = 4'hF;
    if1.ReqAddr[63:32]  = 32'h0000_0040;
    if1.ReqWData[63:32] = 32'hA5A5_0000;
    push1(1, 1'b1, 32'h0000_0040, 32'hA5A5_0000, 4'hF);
    if1.ReqValid[1] = 1'b1;
    cyc  = 0;
    last = 0;
    for (int n = 0; n < 4; n++) begin
      k = 0;
      #1;
      while (!if1.ReqReady[1] && k < 20) begin @(negedge CLK); #1; k++; cyc++; end
      check("t5_grant", 64'(if1.ReqReady), 64'd2);
      if (n > 0) check("t5_gap", 64'(cyc - last), 64'd3);
      last = cyc;
      @(negedge CLK);
      cyc++;
      if (n < 3) begin
        if1.ReqAddr[63:32]  = 32'h0000_0044 + 32'(4 * n);
        if1.ReqWData[63:32] = 32'hA5A5_0001 + 32'(n);
        push1(1, 1'b1, 32'h0000_0044 + 32'(4 * n), 32'hA5A5_0001 + 32'(n), 4'hF);
      end else begin
        if1.ReqValid[1] = 1'b0;
      end
    end
    k = 0;
    while ((q1.size() != 0 || q3.size() != 0) && k < 50) begin @(negedge CLK); k++; end
    check("end_q1_empty", 64'(q1.size()), 64'd0);
    check("end_q3_empty", 64'(q3.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
